// File: rtl/spi_controller.sv
// ----------------------------------------------------------------------------
// spi_controller
//   SPI mode-0 initiator. Takes one register-access request at a time over a
//   valid/ready handshake and sends it as a 16-bit MSB-first frame
//   {rw, addr[6:0], data[7:0]} (rw=1 is a write). CIPO is shifted in on every
//   SCLK rising edge; the last 8 bits are returned on read frames.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write/addr/wdata  request fields, latched on acceptance
//   rsp_valid             one-cycle pulse when a frame completes
//   rsp_rdata             last 8 CIPO bits of the most recent read frame
//   busy                  high from acceptance until back in idle
//   sclk, ncs, copi       SPI outputs (all registered)
//   cipo                  SPI input, already synchronous to clk
// ----------------------------------------------------------------------------
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    input  logic       cipo
);

    localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic [14:0]     tx_q, tx_d;      // frame bits still to be sent after the MSB
    logic [7:0]      rx_q, rx_d;
    logic            wr_q, wr_d;
    logic            sclk_q, sclk_d;
    logic            ncs_q, ncs_d;
    logic            copi_q, copi_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;

    logic div_done;
    logic gap_done;

    assign div_done = (cnt_q == CW'(CLK_DIV - 1));
    assign gap_done = (cnt_q == CW'(CS_GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            sclk_q      <= 1'b0;
            ncs_q       <= 1'b1;
            copi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            sclk_q      <= sclk_d;
            ncs_q       <= ncs_d;
            copi_q      <= copi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        sclk_d      = sclk_q;
        ncs_d       = ncs_q;
        copi_d      = copi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d = SETUP;
                    tx_d    = {req_addr, req_wdata};
                    wr_d    = req_write;
                    bit_d   = '0;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    copi_d  = req_write;
                end
            end
            SETUP: begin
                if (div_done) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], cipo};
                end
            end
            SHIFT: begin
                if (div_done) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: bit_q counts completed bits; after the
                        // 16th fall copi keeps bit 0 until HOLD ends.
                        sclk_d = 1'b0;
                        if (bit_q == 5'd15) begin
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q + 5'd1;
                            copi_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                        end
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], cipo};
                    end
                end
            end
            HOLD: begin
                if (div_done) begin
                    cnt_d       = '0;
                    state_d     = GAP;
                    ncs_d       = 1'b1;
                    copi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!wr_q) begin
                        rsp_rdata_d = rx_q;
                    end
                end
            end
            GAP: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready;
    assign sclk      = sclk_q;
    assign ncs       = ncs_q;
    assign copi      = copi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// ----------------------------------------------------------------------------
// tb_spi_controller
//   Directed bench for spi_controller (CLK_DIV=4, CS_GAP=4). Requests push the
//   expected frame/rdata into a scoreboard queue; a wire monitor rebuilds each
//   frame from COPI on SCLK rises, measures nCS timing and the response, and
//   pushes it to an observation queue that the directed steps pop and compare.
// ----------------------------------------------------------------------------
module tb_spi_controller;

    localparam int CD  = 4;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic       cipo;

    spi_controller #(.CLK_DIV(CD), .CS_GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        int          nb;
        int          low_len;
        int          first_rise;
        int          gap;
        logic        rsp_at_rise;
        logic [7:0]  rdata;
    } obs_t;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;
    logic [7:0]  model_rdata = '0;
    logic [15:0] cipo_pat = '0;

    // Peripheral-side CIPO: bit n of the pattern is presented after n SCLK falls.
    int nfall = 0;
    always @(posedge ncs or negedge sclk) begin
        if (ncs) nfall = 0;
        else     nfall = nfall + 1;
    end
    assign cipo = (nfall < 16) ? cipo_pat[15 - nfall] : 1'b0;

    // Wire monitor, sampled 1 time unit after each rising clk edge.
    int   cyc = 0;
    int   f_cyc = 0;
    int   r_cyc = -1;
    logic ncs_p = 1'b1;
    logic sclk_p = 1'b0;
    obs_t cur;
    initial begin
        cur.frame = '0; cur.nb = 0; cur.low_len = 0; cur.first_rise = -1;
        cur.gap = -1; cur.rsp_at_rise = 1'b0; cur.rdata = '0;
    end
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (ncs_p && !ncs) begin
            f_cyc          = cyc;
            cur.gap        = (r_cyc >= 0) ? cyc - r_cyc : -1;
            cur.nb         = 0;
            cur.frame      = '0;
            cur.first_rise = -1;
        end
        if (!ncs && !sclk_p && sclk) begin
            if (cur.nb == 0) cur.first_rise = cyc - f_cyc;
            cur.frame = {cur.frame[14:0], copi};
            cur.nb    = cur.nb + 1;
        end
        if (!ncs_p && ncs) begin
            r_cyc           = cyc;
            cur.low_len     = cyc - f_cyc;
            cur.rsp_at_rise = rsp_valid;
            cur.rdata       = rsp_rdata;
            obs_q.push_back(cur);
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        ncs_p  = ncs;
        sclk_p = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic keep);
        exp_t e;
        int   n;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        e.frame   = {w, a, d};
        if (!w) model_rdata = cipo_pat[7:0];
        e.rdata   = model_rdata;
        exp_q.push_back(e);
        n = 0;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", (n < 5000), 1);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_obs(output logic ok);
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (obs_q.size() != 0);
        chk("frame_wait", ok, 1);
    endtask

    task automatic check_frame(input string tag, output int gap);
        logic ok;
        obs_t o;
        exp_t e;
        gap = -1;
        wait_obs(ok);
        if (ok && exp_q.size() != 0) begin
            o   = obs_q.pop_front();
            e   = exp_q.pop_front();
            gap = o.gap;
            chk({tag, "_frame"}, o.frame, e.frame);
            chk({tag, "_bits"}, o.nb, 16);
            chk({tag, "_ncs_low"}, o.low_len, 33 * CD);
            chk({tag, "_first_rise"}, o.first_rise, CD);
            chk({tag, "_rsp_valid"}, o.rsp_at_rise, 1);
            chk({tag, "_rdata"}, o.rdata, e.rdata);
        end
    endtask

    initial begin
        int   g;
        int   n;
        int   rsp_before;
        logic ok;
        obs_t o;
        exp_t e;

        // 1: reset, then idle with no request
        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_ncs", ncs, 1);
        chk("idle_sclk", sclk, 0);
        chk("idle_copi", copi, 0);
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rsp_cnt", rsp_cnt, 0);
        chk("idle_no_frames", obs_q.size(), 0);

        // 2: write 0x04 <- 0x80
        issue(1'b1, 7'h04, 8'h80, 1'b0);
        chk("wr_busy", busy, 1);
        chk("wr_ready_low", req_ready, 0);
        chk("wr_expected_const", exp_q[0].frame, 16'h8480);
        check_frame("wr04", g);
        chk("wr_rsp_cnt", rsp_cnt, 1);

        // 3: read 0x01 with CIPO data 0xA5
        cipo_pat = 16'h00A5;
        issue(1'b0, 7'h01, 8'h3C, 1'b0);
        check_frame("rd01", g);

        // 4: back-to-back writes with req_valid held high
        issue(1'b1, 7'h10, 8'h11, 1'b1);
        issue(1'b1, 7'h22, 8'h33, 1'b0);
        check_frame("b2b_a", g);
        check_frame("b2b_b", g);
        chk("b2b_ncs_high", g, GAP + 1);

        // 5: request pulsed while busy is ignored
        rsp_before = rsp_cnt;
        issue(1'b1, 7'h05, 8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        req_write = 1'b1; req_addr = 7'h7F; req_wdata = 8'hEE; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_frame("busy_ign", g);
        repeat (200) @(negedge clk);
        chk("busy_ign_frames", obs_q.size(), 0);
        chk("busy_ign_rsp", rsp_cnt, rsp_before + 1);

        // 6: reset at bit 7 of a write to 0x00
        rsp_before = rsp_cnt;
        issue(1'b1, 7'h00, 8'hFF, 1'b0);
        n = 0;
        while (cur.nb != 7 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_bit7", cur.nb, 7);
        rst_n = 1'b0;
        #1;
        chk("abort_ncs", ncs, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_copi", copi, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rdata", rsp_rdata, 0);
        model_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_obs(ok);
        if (ok) begin
            o = obs_q.pop_front();
            chk("abort_partial_bits", o.nb, 7);
            chk("abort_no_rsp", o.rsp_at_rise, 0);
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("abort_rsp_cnt", rsp_cnt, rsp_before);

        issue(1'b1, 7'h02, 8'h41, 1'b0);
        check_frame("post_wr", g);
        cipo_pat = 16'h00C3;
        issue(1'b0, 7'h03, 8'h00, 1'b0);
        check_frame("post_rd", g);
        repeat (20) @(negedge clk);
        chk("total_rsp_cnt", rsp_cnt, 7);
        chk("final_idle_ncs", ncs, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
